avalon_multichannel_timer: RTL and testbench
============================================

AVALON_MULTICHANNEL_TIMER -- requirements
Module: avalon_multichannel_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..8) SHALL be supported.
REQ-002 Parameter CNT_WIDTH, default 32, counter/period width in bits (8..32) SHALL be supported.
REQ-003 Parameter RESET_PERIOD, default 49999, reset value of every channel's period and counter.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  clog2(NUM_CH)+2  {channel, reg[1:0]}.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  OR of all per-channel interrupts.
REQ-012 irq_vec  output  NUM_CH  per-channel interrupt lines.

Function
REQ-013 Per-channel register map SHALL be: reg 0 STATUS, reg 1 CONTROL, reg 2 PERIOD, reg 3 SNAPSHOT.
REQ-014 STATUS read SHALL return bit0 TO and bit1 RUN, with other bits 0; any write SHALL clear TO.
REQ-015 CONTROL SHALL store bit0 ITO, bit1 CONT and bits[15:8] PRESC; bits 2 (START) and 3 (STOP) SHALL be write-only strobes that read as 0.
REQ-016 PERIOD write SHALL load writedata[CNT_WIDTH-1:0], stop the channel, and reload the counter from the new period on the next cycle.
REQ-017 SNAPSHOT write SHALL capture the live counter; read SHALL return the captured value, zero-extended.
REQ-018 Read latency SHALL be exactly 1 cycle: readdata is valid the cycle after the address is presented; unmapped channel indices SHALL read 0.
REQ-019 Prescaler: a per-channel tick SHALL fire once every PRESC+1 clocks while RUN=1; the prescale count SHALL reset to 0 on START and on PERIOD write.
REQ-020 On a tick with counter≠0, the counter SHALL decrement by 1.
REQ-021 On a tick with counter=0: reload from PERIOD, set TO, and clear RUN if CONT=0.
REQ-022 Timeout period SHALL equal (PERIOD+1)*(PRESC+1) clocks from START.
REQ-023 PERIOD=0 SHALL give a timeout on every tick.
REQ-024 START and STOP in the same write: START SHALL win.
REQ-025 STATUS write in the same cycle as a timeout: the clear SHALL win (TO=0).
REQ-026 START while running SHALL NOT reload the counter but SHALL restart the prescaler.
REQ-027 irq_vec[i] SHALL equal TO[i] AND ITO[i], combinationally from registered state; irq = |irq_vec.
REQ-028 Channels SHALL be fully independent; a write SHALL affect only the addressed channel.
REQ-029 Writes SHALL take effect on the clock edge on which chipselect=1 and write_n=0.

Reset
REQ-030 On reset_n=0, asynchronously: counter=PERIOD=RESET_PERIOD, RUN=0, TO=0, CONTROL=0, prescale count=0, SNAPSHOT=0, readdata=0, irq=0, irq_vec=0.
REQ-031 Reset asserted mid-count SHALL abort the count with no pending TO after release.
REQ-032 After release, no channel SHALL count until START is written.

Verification
REQ-033 Ch0: PERIOD=9, CONTROL=0x6 (START|CONT), PRESC=0 -> TO every 10 clocks, RUN remains 1, irq stays 0 (ITO=0).
REQ-034 Ch1: PERIOD=3, CONTROL=0x0305 (PRESC=3, START, ITO) -> single TO at 16 clocks, RUN falls to 0, irq and irq_vec[1] go to 1; STATUS write -> irq returns to 0.
REQ-035 Ch2 running: PERIOD write of 100 -> RUN=0 next cycle, counter reads 100 via SNAPSHOT, no TO.
REQ-036 Timeout and STATUS write coincide on ch0 -> TO=0; CONTROL write 0xC -> RUN=1 (START wins).
REQ-037 Ch3 running with PERIOD=1000: snapshot at 5 clocks after START -> SNAPSHOT reads 995; reads of ch0 PERIOD/CONTROL are unaffected.
REQ-038 reset_n pulsed low mid-count on all channels -> all registers at reset values, readdata=0, no irq after release.

Source files
------------

// File: rtl/avalon_multichannel_timer.sv
// rtl/avalon_multichannel_timer.sv - multichannel prescaled down-counter timer with Avalon-MM register slave
module avalon_multichannel_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_PERIOD = 49999,
    localparam int AW          = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [CNT_WIDTH-1:0] RST_P = CNT_WIDTH'(RESET_PERIOD);

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_CONTROL  = 2'd1;
    localparam logic [1:0] REG_PERIOD   = 2'd2;
    localparam logic [1:0] REG_SNAPSHOT = 2'd3;

    logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
    logic [CNT_WIDTH-1:0] period [NUM_CH];
    logic [CNT_WIDTH-1:0] snap   [NUM_CH];
    logic [7:0]           presc  [NUM_CH];
    logic [7:0]           pcnt   [NUM_CH];
    logic [NUM_CH-1:0]    run;
    logic [NUM_CH-1:0]    to;
    logic [NUM_CH-1:0]    ito;
    logic [NUM_CH-1:0]    cont;

    logic [NUM_CH-1:0]    ch_wr;
    logic [NUM_CH-1:0]    tick;
    logic [AW-1:0]        ch_idx;
    logic [1:0]           reg_sel;
    logic                 wr_en;
    logic                 rd_en;
    logic [31:0]          rd_mux;

    assign ch_idx  = address >> 2;
    assign reg_sel = address[1:0];
    assign wr_en   = chipselect & ~write_n;
    assign rd_en   = chipselect & write_n;

    // Per-channel write decode and prescaler tick (tick only fires while running)
    always_comb begin
        ch_wr = '0;
        tick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = wr_en && (ch_idx == AW'(i));
            tick[i]  = run[i] && (pcnt[i] == presc[i]);
        end
    end

    // Channel state: prescale/count/timeout first, then register writes override
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= RST_P;
                period[i] <= RST_P;
                snap[i]   <= '0;
                presc[i]  <= '0;
                pcnt[i]   <= '0;
                run[i]    <= 1'b0;
                to[i]     <= 1'b0;
                ito[i]    <= 1'b0;
                cont[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (run[i]) begin
                    if (tick[i]) begin
                        pcnt[i] <= '0;
                        if (cnt[i] == '0) begin
                            cnt[i] <= period[i];
                            to[i]  <= 1'b1;
                            if (!cont[i]) begin
                                run[i] <= 1'b0;
                            end
                        end else begin
                            cnt[i] <= cnt[i] - CNT_WIDTH'(1);
                        end
                    end else begin
                        pcnt[i] <= pcnt[i] + 8'd1;
                    end
                end
                if (ch_wr[i]) begin
                    case (reg_sel)
                        REG_STATUS: begin
                            to[i] <= 1'b0;
                        end
                        REG_CONTROL: begin
                            ito[i]   <= writedata[0];
                            cont[i]  <= writedata[1];
                            presc[i] <= writedata[15:8];
                            if (writedata[2]) begin
                                run[i]  <= 1'b1;
                                pcnt[i] <= '0;
                            end else if (writedata[3]) begin
                                run[i] <= 1'b0;
                            end
                        end
                        REG_PERIOD: begin
                            period[i] <= writedata[CNT_WIDTH-1:0];
                            cnt[i]    <= writedata[CNT_WIDTH-1:0];
                            run[i]    <= 1'b0;
                            pcnt[i]   <= '0;
                        end
                        default: begin
                            snap[i] <= cnt[i];
                        end
                    endcase
                end
            end
        end
    end

    // Read mux; channel indices with no channel behind them return 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == AW'(i)) begin
                case (reg_sel)
                    REG_STATUS:   rd_mux = {30'd0, run[i], to[i]};
                    REG_CONTROL:  rd_mux = {16'd0, presc[i], 4'd0, 2'b00, cont[i], ito[i]};
                    REG_PERIOD:   rd_mux = 32'(period[i]);
                    default:      rd_mux = 32'(snap[i]);
                endcase
            end
        end
    end

    // Registered read data, one cycle after the address is presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    // Interrupts straight from registered TO/ITO
    always_comb begin
        irq_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            irq_vec[i] = to[i] & ito[i];
        end
        irq = |irq_vec;
    end

endmodule

// File: tb/tb_avalon_multichannel_timer.sv
// tb/tb_avalon_multichannel_timer.sv - self-checking bench for avalon_multichannel_timer
module tb_avalon_multichannel_timer;

    localparam int NCH = 4;
    localparam int RP  = 49999;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a channel ticks on every (PRESC+1)-th edge counted from its last prescaler restart
    int unsigned m_period [NCH];
    int unsigned m_cnt    [NCH];
    int unsigned m_snap   [NCH];
    int unsigned m_presc  [NCH];
    bit          m_run    [NCH];
    bit          m_to     [NCH];
    bit          m_ito    [NCH];
    bit          m_cont   [NCH];
    int          m_start  [NCH];
    int          edge_n;
    logic [31:0] m_rd;

    avalon_multichannel_timer #(
        .NUM_CH(NCH),
        .CNT_WIDTH(32),
        .RESET_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_period[c] = RP;
            m_cnt[c]    = RP;
            m_snap[c]   = 0;
            m_presc[c]  = 0;
            m_run[c]    = 0;
            m_to[c]     = 0;
            m_ito[c]    = 0;
            m_cont[c]   = 0;
            m_start[c]  = 0;
        end
        m_rd = 0;
    endtask

    function automatic logic [31:0] model_reg(input int c, input int r);
        case (r)
            0:       return {30'd0, m_run[c], m_to[c]};
            1:       return {16'd0, m_presc[c][7:0], 6'd0, m_cont[c], m_ito[c]};
            2:       return m_period[c];
            default: return m_snap[c];
        endcase
    endfunction

    function automatic logic [3:0] model_irqvec();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    function automatic bit tick_at(input int c, input int e);
        return m_run[c] && (((e - m_start[c]) % (int'(m_presc[c]) + 1)) == 0);
    endfunction

    task automatic model_edge(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        int unsigned pre;
        if (cs && wn) m_rd = model_reg(int'(a[3:2]), int'(a[1:0]));
        edge_n++;
        for (int c = 0; c < NCH; c++) begin
            pre = m_cnt[c];
            if (tick_at(c, edge_n)) begin
                if (m_cnt[c] == 0) begin
                    m_cnt[c] = m_period[c];
                    m_to[c]  = 1;
                    if (!m_cont[c]) m_run[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end
            if (cs && !wn && int'(a[3:2]) == c) begin
                case (a[1:0])
                    2'd0: m_to[c] = 0;
                    2'd1: begin
                        m_ito[c]   = d[0];
                        m_cont[c]  = d[1];
                        m_presc[c] = d[15:8];
                        if (d[2]) begin
                            m_run[c]   = 1;
                            m_start[c] = edge_n;
                        end else if (d[3]) begin
                            m_run[c] = 0;
                        end
                    end
                    2'd2: begin
                        m_period[c] = d;
                        m_cnt[c]    = d;
                        m_run[c]    = 0;
                        m_start[c]  = edge_n;
                    end
                    default: m_snap[c] = pre;
                endcase
            end
        end
    endtask

    task automatic cyc(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_edge(cs, wn, a, d);
        #1;
        chk("irq_vec", 32'(irq_vec), 32'(model_irqvec()));
        chk("irq", 32'(irq), 32'(|model_irqvec()));
        chk("readdata", readdata, m_rd);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 4'd0, 32'd0);
    endtask

    task automatic rd_exp(input string tag, input logic [3:0] a, input logic [31:0] exp);
        rd(a);
        chk(tag, readdata, exp);
    endtask

    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_readdata", readdata, 32'd0);
        chk("rst_async_irq", 32'(irq), 32'd0);
        chk("rst_async_irq_vec", 32'(irq_vec), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        logic [31:0] d;
        int c, r, op, pr, bits;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        edge_n     = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_irq_vec", 32'(irq_vec), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NCH; i++) begin
            rd_exp("reset_status", 4'(i * 4 + 0), 32'd0);
            rd_exp("reset_control", 4'(i * 4 + 1), 32'd0);
            rd_exp("reset_period", 4'(i * 4 + 2), RP);
            rd_exp("reset_snapshot", 4'(i * 4 + 3), 32'd0);
        end
        idle(20);
        wr(4'd3, 32'd0);
        rd_exp("no_count_before_start", 4'd3, RP);

        // ch0 continuous, PERIOD=9, no prescale: TO lands exactly 10 clocks after START
        wr(4'd2, 32'd9);
        wr(4'd1, 32'h6);
        idle(9);
        rd_exp("ch0_before_to", 4'd0, 32'h2);
        rd_exp("ch0_first_to", 4'd0, 32'h3);
        idle(25);
        chk("ch0_ito0_no_irq", 32'(irq), 32'd0);

        // ch1 one-shot, PERIOD=3, PRESC=3, ITO: single TO at 16 clocks
        wr(4'd6, 32'd3);
        wr(4'd5, 32'h0305);
        idle(15);
        chk("ch1_no_irq_yet", 32'(irq), 32'd0);
        rd_exp("ch1_status_at_16", 4'd4, 32'h2);
        chk("ch1_irq", 32'(irq), 32'd1);
        chk("ch1_irq_vec", 32'(irq_vec), 32'h2);
        rd_exp("ch1_run_fell", 4'd4, 32'h1);
        rd_exp("ch1_control", 4'd5, 32'h0301);
        wr(4'd4, 32'd0);
        chk("ch1_irq_cleared", 32'(irq), 32'd0);

        // ch2 stopped by PERIOD write while running
        wr(4'd10, 32'd200);
        wr(4'd9, 32'h4);
        idle(10);
        wr(4'd10, 32'd100);
        rd_exp("ch2_run_cleared", 4'd8, 32'd0);
        wr(4'd11, 32'd0);
        rd_exp("ch2_snapshot", 4'd11, 32'd100);
        idle(5);
        rd_exp("ch2_no_to", 4'd8, 32'd0);

        // ch0 STATUS write on the timeout edge: clear wins
        guard = 0;
        while (!(tick_at(0, edge_n + 1) && m_cnt[0] == 0) && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("ch0_to_found", 32'(guard < 50), 32'd1);
        wr(4'd0, 32'd0);
        rd_exp("ch0_clear_wins", 4'd0, 32'h2);
        wr(4'd1, 32'hC);
        rd_exp("ch0_start_wins", 4'd0, 32'h2);

        // ch3 snapshot 5 clocks into a 1000 count
        wr(4'd14, 32'd1000);
        wr(4'd13, 32'h4);
        idle(5);
        wr(4'd15, 32'd0);
        rd_exp("ch3_snapshot", 4'd15, 32'd995);
        rd_exp("ch0_period_kept", 4'd2, 32'd9);
        rd_exp("ch0_control_kept", 4'd1, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            c  = $urandom_range(0, NCH - 1);
            r  = $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            if (op < 4) begin
                idle(1);
            end else if (op < 7) begin
                rd(4'(c * 4 + r));
            end else begin
                case (r)
                    1: begin
                        pr   = $urandom_range(0, 3);
                        bits = $urandom_range(0, 15);
                        if (m_run[c] && pr != int'(m_presc[c])) bits = bits | 4;
                        d = {16'd0, 8'(pr), 4'd0, 4'(bits)};
                    end
                    2:       d = $urandom_range(0, 12);
                    default: d = $urandom;
                endcase
                wr(4'(c * 4 + r), d);
            end
        end

        // reset mid-count on all channels
        for (int i = 0; i < NCH; i++) begin
            wr(4'(i * 4 + 2), 32'd5);
            wr(4'(i * 4 + 1), 32'h7);
        end
        idle(8);
        pulse_reset();
        idle(1);
        chk("post_reset_irq", 32'(irq), 32'd0);
        chk("post_reset_readdata", readdata, 32'd0);
        for (int i = 0; i < NCH; i++) begin
            rd_exp("post_rst_status", 4'(i * 4 + 0), 32'd0);
            rd_exp("post_rst_control", 4'(i * 4 + 1), 32'd0);
            rd_exp("post_rst_period", 4'(i * 4 + 2), RP);
            rd_exp("post_rst_snapshot", 4'(i * 4 + 3), 32'd0);
        end
        idle(30);
        chk("post_rst_no_irq", 32'(irq), 32'd0);
        rd_exp("post_rst_ch2_idle", 4'd8, 32'd0);
        wr(4'd11, 32'd0);
        rd_exp("post_rst_ch2_cnt", 4'd11, RP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
